// File: rtl/rf_arbiter_pkg.sv
// Shared constants and FSM encoding for the two-client register-file arbiter.
package rf_arbiter_pkg;
  localparam int DW_C = 8;
  localparam int AW_C = 3;
  localparam int NCLI = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  function automatic logic other_cli(input logic c);
    return ~c;
  endfunction
endpackage

// File: rtl/register_file.sv
// 8-entry register file: r0 reads as zero, combinational reads, one write port.
module register_file #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          WEN,
  input  logic [AW-1:0] RW,
  input  logic [AW-1:0] RX,
  input  logic [AW-1:0] RY,
  input  logic [DW-1:0] busW,
  output logic [DW-1:0] busX,
  output logic [DW-1:0] busY
);
  logic [(1<<AW)-1:0][DW-1:0] mem_q;

  // r0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                     mem_q <= '0;
    else if (WEN && (RW != '0))     mem_q[RW] <= busW;
  end

  assign busX = mem_q[RX];
  assign busY = mem_q[RY];
endmodule

// File: rtl/rf_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, rr breaks ties.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       rr_i,
  output logic [1:0] gnt_o
);
  always_comb begin
    gnt_o = 2'b00;
    case (valid_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = rr_i ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end
endmodule

// File: rtl/rf_arbiter.sv
// Arbitrates two clients onto one register-file port: IDLE -> ISSUE -> RESP per op.
module rf_arbiter
  import rf_arbiter_pkg::*;
#(
  parameter int DW = DW_C,
  parameter int AW = AW_C
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          c0_valid,
  output logic          c0_ready,
  input  logic          c0_wen,
  input  logic [AW-1:0] c0_rw,
  input  logic [AW-1:0] c0_rx,
  input  logic [AW-1:0] c0_ry,
  input  logic [DW-1:0] c0_wdata,
  output logic          c0_rsp_valid,
  input  logic          c0_rsp_ready,
  output logic [DW-1:0] c0_rdata_x,
  output logic [DW-1:0] c0_rdata_y,
  input  logic          c1_valid,
  output logic          c1_ready,
  input  logic          c1_wen,
  input  logic [AW-1:0] c1_rw,
  input  logic [AW-1:0] c1_rx,
  input  logic [AW-1:0] c1_ry,
  input  logic [DW-1:0] c1_wdata,
  output logic          c1_rsp_valid,
  input  logic          c1_rsp_ready,
  output logic [DW-1:0] c1_rdata_x,
  output logic [DW-1:0] c1_rdata_y,
  output logic          WEN,
  output logic [AW-1:0] RW,
  output logic [AW-1:0] RX,
  output logic [AW-1:0] RY,
  output logic [DW-1:0] busW,
  input  logic [DW-1:0] busX,
  input  logic [DW-1:0] busY
);
  logic [NCLI-1:0]         cli_valid, cli_wen, cli_rsp_ready, gnt;
  logic [NCLI-1:0][AW-1:0] cli_rw, cli_rx, cli_ry;
  logic [NCLI-1:0][DW-1:0] cli_wdata;
  logic                    sel;

  state_e                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    rr_q, rr_d;
  logic                    wen_q, wen_d;
  logic [AW-1:0]           rw_q, rw_d, rx_q, rx_d, ry_q, ry_d;
  logic [DW-1:0]           busw_q, busw_d;
  logic [NCLI-1:0][DW-1:0] rdx_q, rdy_q;

  assign cli_valid     = {c1_valid, c0_valid};
  assign cli_wen       = {c1_wen, c0_wen};
  assign cli_rsp_ready = {c1_rsp_ready, c0_rsp_ready};
  assign cli_rw        = {c1_rw, c0_rw};
  assign cli_rx        = {c1_rx, c0_rx};
  assign cli_ry        = {c1_ry, c0_ry};
  assign cli_wdata     = {c1_wdata, c0_wdata};

  rr_arb2 u_arb (
    .valid_i (cli_valid),
    .rr_i    (rr_q),
    .gnt_o   (gnt)
  );

  assign sel = gnt[1];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    wen_d   = 1'b0;
    rw_d    = rw_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    busw_d  = busw_q;
    case (state_q)
      S_IDLE: begin
        if (|gnt) begin
          state_d = S_ISSUE;
          owner_d = sel;
          wen_d   = cli_wen[sel];
          rw_d    = cli_rw[sel];
          rx_d    = cli_rx[sel];
          ry_d    = cli_ry[sel];
          busw_d  = cli_wdata[sel];
        end
      end
      S_ISSUE: state_d = S_RESP;
      S_RESP: begin
        if (cli_rsp_ready[owner_q]) begin
          state_d = S_IDLE;
          rr_d    = other_cli(owner_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      wen_q   <= 1'b0;
      rw_q    <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      busw_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      wen_q   <= wen_d;
      rw_q    <= rw_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      busw_q  <= busw_d;
    end
  end

  // Read data sampled as the write lands, so same-op reads see the old value.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rdx_q <= '0;
      rdy_q <= '0;
    end else if (state_q == S_ISSUE) begin
      rdx_q[owner_q] <= busX;
      rdy_q[owner_q] <= busY;
    end
  end

  // Ready is gated by reset so nothing is accepted while reset is held.
  assign c0_ready     = Rst_n && (state_q == S_IDLE) && gnt[0];
  assign c1_ready     = Rst_n && (state_q == S_IDLE) && gnt[1];
  assign c0_rsp_valid = (state_q == S_RESP) && !owner_q;
  assign c1_rsp_valid = (state_q == S_RESP) &&  owner_q;
  assign c0_rdata_x   = rdx_q[0];
  assign c0_rdata_y   = rdy_q[0];
  assign c1_rdata_x   = rdx_q[1];
  assign c1_rdata_y   = rdy_q[1];

  assign WEN  = wen_q;
  assign RW   = rw_q;
  assign RX   = rx_q;
  assign RY   = ry_q;
  assign busW = busw_q;
endmodule

// File: tb/tb_rf_arbiter.sv
// Directed and randomized checks of rf_arbiter driving a register_file.
module tb_rf_arbiter;
  logic       Clk = 1'b0;
  logic       Rst_n, rf_rst_n;
  logic [1:0] v, rsp_rdy;
  logic       wen [2];
  logic [2:0] rw [2], rx [2], ry [2];
  logic [7:0] wd [2];

  logic       c0_ready, c1_ready, c0_rsp_valid, c1_rsp_valid, WEN;
  logic [7:0] c0_rdata_x, c0_rdata_y, c1_rdata_x, c1_rdata_y, busW, busX, busY;
  logic [2:0] RW, RX, RY;

  int         n_pass = 0, n_fail = 0;
  int         pref;
  logic [7:0] ref_mem [8];
  logic [1:0] pend;

  always #5 Clk = ~Clk;

  rf_arbiter dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .c0_valid(v[0]), .c0_ready(c0_ready), .c0_wen(wen[0]), .c0_rw(rw[0]),
    .c0_rx(rx[0]), .c0_ry(ry[0]), .c0_wdata(wd[0]), .c0_rsp_valid(c0_rsp_valid),
    .c0_rsp_ready(rsp_rdy[0]), .c0_rdata_x(c0_rdata_x), .c0_rdata_y(c0_rdata_y),
    .c1_valid(v[1]), .c1_ready(c1_ready), .c1_wen(wen[1]), .c1_rw(rw[1]),
    .c1_rx(rx[1]), .c1_ry(ry[1]), .c1_wdata(wd[1]), .c1_rsp_valid(c1_rsp_valid),
    .c1_rsp_ready(rsp_rdy[1]), .c1_rdata_x(c1_rdata_x), .c1_rdata_y(c1_rdata_y),
    .WEN(WEN), .RW(RW), .RX(RX), .RY(RY), .busW(busW), .busX(busX), .busY(busY)
  );

  register_file u_rf (
    .Clk(Clk), .Rst_n(rf_rst_n), .WEN(WEN), .RW(RW), .RX(RX), .RY(RY),
    .busW(busW), .busX(busX), .busY(busY)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rdx(input int g);
    return (g == 1) ? c1_rdata_x : c0_rdata_x;
  endfunction

  function automatic logic [7:0] rdy(input int g);
    return (g == 1) ? c1_rdata_y : c0_rdata_y;
  endfunction

  task automatic set_req(input int g, input logic w, input logic [2:0] a_w,
                         input logic [2:0] a_x, input logic [2:0] a_y, input logic [7:0] d);
    wen[g] = w; rw[g] = a_w; rx[g] = a_x; ry[g] = a_y; wd[g] = d;
    v[g] = 1'b1;
    #1;
  endtask

  // One complete op for client g, entered at a negedge with the DUT in IDLE.
  task automatic run_op(input int g, input bit keep, input int hold);
    logic [7:0] ex, ey;
    logic [1:0] onehot;
    onehot = (g == 1) ? 2'b10 : 2'b01;
    ex = ref_mem[rx[g]];
    ey = ref_mem[ry[g]];
    chk("grant", 32'({c1_ready, c0_ready}), 32'(onehot));
    @(posedge Clk);
    @(negedge Clk);
    if (!keep) v[g] = 1'b0;
    #1;
    chk("ready_busy", 32'({c1_ready, c0_ready}), 32'd0);
    chk("wen_issue", 32'(WEN), 32'(wen[g]));
    chk("rw", 32'(RW), 32'(rw[g]));
    chk("rx", 32'(RX), 32'(rx[g]));
    chk("ry", 32'(RY), 32'(ry[g]));
    chk("busw", 32'(busW), 32'(wd[g]));
    if (wen[g] && rw[g] != 3'd0) ref_mem[rw[g]] = wd[g];
    @(negedge Clk); #1;
    chk("wen_resp", 32'(WEN), 32'd0);
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin
        @(negedge Clk); #1;
        chk("ready_hold", 32'({c1_ready, c0_ready}), 32'd0);
      end
      chk("rsp_valid", 32'({c1_rsp_valid, c0_rsp_valid}), 32'(onehot));
      chk("rdata_x", 32'(rdx(g)), 32'(ex));
      chk("rdata_y", 32'(rdy(g)), 32'(ey));
    end
    rsp_rdy[g] = 1'b1;
    @(negedge Clk);
    rsp_rdy[g] = 1'b0;
    #1;
    chk("rsp_done", 32'({c1_rsp_valid, c0_rsp_valid}), 32'd0);
    pref = 1 - g;
  endtask

  initial begin
    Rst_n = 1'b0; rf_rst_n = 1'b0; v = 2'b11; rsp_rdy = 2'b00; pref = 0;
    for (int i = 0; i < 2; i++) begin
      wen[i] = 1'b0; rw[i] = 3'd0; rx[i] = 3'd0; ry[i] = 3'd0; wd[i] = 8'd0;
    end
    for (int i = 0; i < 8; i++) ref_mem[i] = 8'd0;

    // Reset state, with both clients requesting.
    #2;
    chk("rst_ready", 32'({c1_ready, c0_ready}), 32'd0);
    chk("rst_wen", 32'(WEN), 32'd0);
    chk("rst_addr", 32'({RW, RX, RY}), 32'd0);
    chk("rst_busw", 32'(busW), 32'd0);
    chk("rst_rspv", 32'({c1_rsp_valid, c0_rsp_valid}), 32'd0);
    chk("rst_rdata", 32'({c0_rdata_x, c0_rdata_y, c1_rdata_x, c1_rdata_y}), 32'd0);
    repeat (2) @(negedge Clk);
    v = 2'b00; Rst_n = 1'b1; rf_rst_n = 1'b1;
    #1;

    // Both clients valid continuously: grants alternate starting at c0.
    set_req(0, 1'b0, 3'd0, 3'd1, 3'd2, 8'd0);
    set_req(1, 1'b0, 3'd0, 3'd3, 3'd4, 8'd0);
    for (int i = 0; i < 4; i++) begin
      chk("rr_order", 32'(c1_ready), 32'(i % 2));
      run_op(pref, 1'b1, 0);
    end
    v = 2'b00;
    #1;

    // Response held off for 5 cycles while c1 waits.
    set_req(0, 1'b1, 3'd6, 3'd6, 3'd0, 8'h77);
    set_req(1, 1'b0, 3'd0, 3'd6, 3'd6, 8'd0);
    run_op(0, 1'b0, 5);
    chk("idle_after_hold", 32'(c1_ready), 32'd1);
    run_op(1, 1'b0, 0);

    // Write then read r3; same-op read sees the old value.
    set_req(0, 1'b1, 3'd3, 3'd3, 3'd3, 8'hA5);
    run_op(0, 1'b0, 0);
    chk("wr_same_op_old", 32'(c0_rdata_x), 32'h00);
    set_req(0, 1'b0, 3'd0, 3'd3, 3'd0, 8'd0);
    run_op(0, 1'b0, 0);
    chk("rd_r3_a5", 32'(c0_rdata_x), 32'hA5);

    // r2 read on both ports.
    set_req(0, 1'b1, 3'd2, 3'd0, 3'd0, 8'h11);
    run_op(0, 1'b0, 0);
    set_req(0, 1'b0, 3'd0, 3'd2, 3'd2, 8'd0);
    run_op(0, 1'b0, 0);
    chk("rd_r2_x", 32'(c0_rdata_x), 32'h11);
    chk("rd_r2_y", 32'(c0_rdata_y), 32'h11);

    // Writes to r0 are issued but r0 stays zero.
    set_req(1, 1'b1, 3'd0, 3'd3, 3'd0, 8'h3C);
    run_op(1, 1'b0, 0);
    chk("c1_rd_r3", 32'(c1_rdata_x), 32'hA5);
    set_req(1, 1'b0, 3'd0, 3'd0, 3'd0, 8'd0);
    run_op(1, 1'b0, 0);
    chk("rd_r0_zero", 32'(c1_rdata_x), 32'h00);

    // Reset asserted during ISSUE of a write to r5.
    set_req(0, 1'b1, 3'd5, 3'd0, 3'd0, 8'h5A);
    run_op(0, 1'b0, 0);
    set_req(0, 1'b1, 3'd5, 3'd5, 3'd5, 8'hFF);
    chk("rst_op_grant", 32'(c0_ready), 32'd1);
    @(posedge Clk);
    @(negedge Clk);
    v[0] = 1'b0;
    #1;
    chk("rst_op_wen", 32'(WEN), 32'd1);
    Rst_n = 1'b0;
    #1;
    chk("abort_wen", 32'(WEN), 32'd0);
    chk("abort_addr", 32'({RW, RX, RY}), 32'd0);
    chk("abort_busw", 32'(busW), 32'd0);
    chk("abort_rspv", 32'({c1_rsp_valid, c0_rsp_valid}), 32'd0);
    chk("abort_rdata", 32'({c0_rdata_x, c0_rdata_y, c1_rdata_x, c1_rdata_y}), 32'd0);
    set_req(1, 1'b0, 3'd0, 3'd5, 3'd0, 8'd0);
    chk("abort_ready", 32'({c1_ready, c0_ready}), 32'd0);
    @(negedge Clk);
    v = 2'b00; Rst_n = 1'b1; pref = 0;
    #1;
    set_req(0, 1'b0, 3'd0, 3'd5, 3'd5, 8'd0);
    run_op(0, 1'b0, 0);
    chk("r5_unchanged", 32'(c0_rdata_x), 32'h5A);

    // Randomized traffic against the reference model.
    pend = 2'b00;
    for (int it = 0; it < 40; it++) begin
      int g;
      for (int c = 0; c < 2; c++) begin
        if (!pend[c] && ($urandom_range(1) == 1)) begin
          set_req(c, 1'($urandom_range(1)), 3'($urandom_range(7)), 3'($urandom_range(7)),
                  3'($urandom_range(7)), 8'($urandom_range(255)));
          pend[c] = 1'b1;
        end
      end
      if (pend == 2'b00) begin
        g = int'($urandom_range(1));
        set_req(g, 1'($urandom_range(1)), 3'($urandom_range(7)), 3'($urandom_range(7)),
                3'($urandom_range(7)), 8'($urandom_range(255)));
        pend[g] = 1'b1;
      end
      g = (pend == 2'b11) ? pref : (pend[1] ? 1 : 0);
      run_op(g, 1'b0, int'($urandom_range(2)));
      pend[g] = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end
endmodule

// File: doc/rf_arbiter.md
RF_ARBITER -- requirements
Module: rf_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning data width; it is fixed to match the 8-bit register file.
REQ-002 The block SHALL have parameter AW, default 3, meaning register address width for 8 registers.
REQ-003 The block SHALL have port Clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 For each client i in {0,1}, the block SHALL have port ci_valid, input, 1 bit: request valid.
REQ-006 For each client i, the block SHALL have port ci_ready, output, 1 bit: request accepted.
REQ-007 For each client i, the block SHALL have port ci_wen, input, 1 bit: request includes a write.
REQ-008 For each client i, the block SHALL have ports ci_rw, ci_rx and ci_ry, input, AW bits each: write address, read-X address and read-Y address.
REQ-009 For each client i, the block SHALL have port ci_wdata, input, DW bits: write data.
REQ-010 For each client i, the block SHALL have port ci_rsp_valid, output, 1 bit: response valid.
REQ-011 For each client i, the block SHALL have port ci_rsp_ready, input, 1 bit: response consumed.
REQ-012 For each client i, the block SHALL have ports ci_rdata_x and ci_rdata_y, output, DW bits each: read results.
REQ-013 The block SHALL have regfile-side outputs WEN (1 bit), RW, RX and RY (AW bits each) and busW (DW bits), all registered.
REQ-014 The block SHALL have regfile-side inputs busX and busY, DW bits each, combinational read data from the register file.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ISSUE and RESP.
REQ-016 Handshake: a transfer SHALL occur on a rising edge where ci_valid=1 and ci_ready=1; clients hold valid and fields stable until that edge.
REQ-017 ci_ready SHALL be combinational and equal 1 only when state=IDLE and client i is the granted client.
REQ-018 Arbitration in IDLE: a single valid client SHALL be granted; if both are valid, the client selected by the round-robin pointer rr SHALL be granted.
REQ-019 On accept, the block SHALL latch the owner, load RX/RY/RW/busW from the granted client, and move to ISSUE.
REQ-020 ISSUE SHALL last exactly 1 cycle, with WEN=ci_wen of the owner; all other cycles SHALL have WEN=0.
REQ-021 At the ISSUE-to-RESP edge, the block SHALL capture busX/busY into the owner's rdata registers, so a read of the address being written returns the pre-write value.
REQ-022 In RESP, owner ci_rsp_valid SHALL be 1 and the rdata outputs SHALL be held stable until ci_rsp_ready=1.
REQ-023 In RESP, the non-owner's rsp_valid SHALL be 0.
REQ-024 On the RESP edge where ci_rsp_ready=1, the block SHALL move to IDLE and set rr to the other client.
REQ-025 Minimum latency SHALL be accept to rsp_valid = 2 cycles, and minimum throughput SHALL be 1 op per 3 cycles.
REQ-026 A request while the block is not in IDLE SHALL wait; ci_ready=0 and there is no queueing.
REQ-027 A write to address 0 SHALL be issued unchanged; the register file keeps r0=0, so a later read of r0 returns 0.
REQ-028 rr SHALL change only at RESP completion, and a lone requester SHALL be re-granted regardless of rr.
REQ-029 RX/RY/RW/busW SHALL hold their last values outside ISSUE.

Reset
REQ-030 While Rst_n=0, state SHALL be IDLE, rr=0 (client 0 first), WEN=0, RW/RX/RY=0, busW=0, all rdata=0, all rsp_valid=0 and all ready=0.
REQ-031 Reset asserted in ISSUE or RESP SHALL abort the op immediately, with WEN forced to 0 asynchronously and no response delivered.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (2 bits: IDLE=0, ISSUE=1, RESP=2) and DW/AW constants.
REQ-033 The sub-module rr_arb2 (2-way round-robin grant from valids and rr) SHALL be used.
REQ-034 The bench SHALL instantiate the team's register_file with rf_arbiter.

Verification
REQ-035 Client 0 writes 8'hA5 to r3, then reads rx=3: rdata_x=8'hA5; the read response in the same op as the write returns the prior value (0).
REQ-036 c0 and c1 valid together after reset, with c1 holding valid until granted: grants occur in order c0, c1, c0, c1 over 4 ops, and each ready pulse lasts 1 cycle.
REQ-037 c1 write 8'h3C to r0, then read r0: rdata_x=8'h00.
REQ-038 Hold c0_rsp_ready=0 for 5 cycles in RESP: rsp_valid and rdata stay stable, c1_ready stays 0, and IDLE is reached 1 cycle after rsp_ready=1.
REQ-039 Assert Rst_n=0 during ISSUE of a write 8'hFF to r5: WEN drops immediately, r5 is unchanged, and all outputs are at reset values.
REQ-040 c0 reads rx=2 and ry=2 after r2=8'h11: both rdata_x and rdata_y equal 8'h11.
